// File: rtl/fetch_controller.sv
// fetch_controller: owns the fetch PC and issues requests to a shared,
// variable-latency instruction memory (one request outstanding at most).
// It feeds the IF/ID register, keeps one response in a hold buffer while
// decode is stalled, and squashes in-flight work on execute redirects.
module fetch_controller #(
    parameter int unsigned          WORD_SIZE  = 32,
    parameter logic [WORD_SIZE-1:0] PC_INITIAL = '0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 PCSrcE,
    input  logic [WORD_SIZE-1:0] PCTargetE,
    input  logic                 StallD,
    output logic                 imem_req,
    output logic [WORD_SIZE-1:0] imem_addr,
    input  logic                 imem_ready,
    input  logic                 imem_valid,
    input  logic [WORD_SIZE-1:0] imem_rdata,
    output logic [WORD_SIZE-1:0] InstrD,
    output logic [WORD_SIZE-1:0] PCD,
    output logic [WORD_SIZE-1:0] PCPlus4D,
    output logic                 ValidD
);

    typedef enum logic [1:0] {
        ST_REQ  = 2'd0,
        ST_WAIT = 2'd1,
        ST_HOLD = 2'd2
    } state_t;

    localparam logic [WORD_SIZE-1:0] PC_STEP    = WORD_SIZE'(4);
    localparam logic [WORD_SIZE-1:0] ALIGN_MASK = {{(WORD_SIZE-2){1'b1}}, 2'b00};

    state_t                 state_q,     state_d;
    logic [WORD_SIZE-1:0]   pcf_q,       pcf_d;
    logic [WORD_SIZE-1:0]   pc_issued_q, pc_issued_d;
    logic                   squash_q,    squash_d;
    logic [WORD_SIZE-1:0]   instrd_q,    instrd_d;
    logic [WORD_SIZE-1:0]   pcd_q,       pcd_d;
    logic [WORD_SIZE-1:0]   pcplus4d_q,  pcplus4d_d;
    logic                   validd_q,    validd_d;
    logic [WORD_SIZE-1:0]   hold_instr_q, hold_instr_d;
    logic [WORD_SIZE-1:0]   hold_pc_q,    hold_pc_d;

    logic [WORD_SIZE-1:0]   issued_plus4;
    logic [WORD_SIZE-1:0]   hold_plus4;

    assign issued_plus4 = pc_issued_q + PC_STEP;
    assign hold_plus4   = hold_pc_q + PC_STEP;

    // Memory request side comes straight from registered state only
    assign imem_req  = (state_q == ST_REQ) && !rst;
    assign imem_addr = pcf_q;

    assign InstrD   = instrd_q;
    assign PCD      = pcd_q;
    assign PCPlus4D = pcplus4d_q;
    assign ValidD   = validd_q;

    // Next-state, fetch PC, hold buffer and decode register update
    always_comb begin
        state_d      = state_q;
        pcf_d        = pcf_q;
        pc_issued_d  = pc_issued_q;
        squash_d     = squash_q;
        instrd_d     = instrd_q;
        pcd_d        = pcd_q;
        pcplus4d_d   = pcplus4d_q;
        validd_d     = validd_q;
        hold_instr_d = hold_instr_q;
        hold_pc_d    = hold_pc_q;

        // Decode drains when not stalled; overwritten below if a word arrives
        if (!StallD) begin
            validd_d = 1'b0;
        end

        if (PCSrcE) begin
            pcf_d    = PCTargetE & ALIGN_MASK;
            validd_d = 1'b0;
            case (state_q)
                ST_WAIT: begin
                    // A response arriving in the redirect cycle closes the
                    // outstanding request, so there is nothing left to squash
                    if (imem_valid) begin
                        state_d  = ST_REQ;
                        squash_d = 1'b0;
                    end else begin
                        state_d  = ST_WAIT;
                        squash_d = 1'b1;
                    end
                end
                default: begin
                    state_d = ST_REQ;
                end
            endcase
        end else begin
            case (state_q)
                ST_REQ: begin
                    if (imem_ready) begin
                        pc_issued_d = pcf_q;
                        state_d     = ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (imem_valid) begin
                        if (squash_q) begin
                            squash_d = 1'b0;
                            state_d  = ST_REQ;
                        end else if (!validd_q || !StallD) begin
                            instrd_d   = imem_rdata;
                            pcd_d      = pc_issued_q;
                            pcplus4d_d = issued_plus4;
                            validd_d   = 1'b1;
                            pcf_d      = issued_plus4;
                            state_d    = ST_REQ;
                        end else begin
                            hold_instr_d = imem_rdata;
                            hold_pc_d    = pc_issued_q;
                            pcf_d        = issued_plus4;
                            state_d      = ST_HOLD;
                        end
                    end
                end
                ST_HOLD: begin
                    if (!StallD) begin
                        instrd_d   = hold_instr_q;
                        pcd_d      = hold_pc_q;
                        pcplus4d_d = hold_plus4;
                        validd_d   = 1'b1;
                        state_d    = ST_REQ;
                    end
                end
                default: begin
                    state_d = ST_REQ;
                end
            endcase
        end
    end

    // State registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_REQ;
            pcf_q        <= PC_INITIAL;
            pc_issued_q  <= PC_INITIAL;
            squash_q     <= 1'b0;
            instrd_q     <= '0;
            pcd_q        <= PC_INITIAL;
            pcplus4d_q   <= '0;
            validd_q     <= 1'b0;
            hold_instr_q <= '0;
            hold_pc_q    <= PC_INITIAL;
        end else begin
            state_q      <= state_d;
            pcf_q        <= pcf_d;
            pc_issued_q  <= pc_issued_d;
            squash_q     <= squash_d;
            instrd_q     <= instrd_d;
            pcd_q        <= pcd_d;
            pcplus4d_q   <= pcplus4d_d;
            validd_q     <= validd_d;
            hold_instr_q <= hold_instr_d;
            hold_pc_q    <= hold_pc_d;
        end
    end

endmodule

// File: tb/tb_fetch_controller.sv
// Directed bench for fetch_controller with a small latency-programmable
// instruction memory model; outputs are sampled 1 time unit after posedge.
module tb_fetch_controller;

    logic        clk = 1'b0;
    logic        rst;
    logic        PCSrcE;
    logic [31:0] PCTargetE;
    logic        StallD;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic        imem_valid;
    logic [31:0] imem_rdata;
    logic [31:0] InstrD;
    logic [31:0] PCD;
    logic [31:0] PCPlus4D;
    logic        ValidD;

    int checks = 0;
    int errors = 0;

    int          lat;
    logic        pend;
    int          cnt;
    logic [31:0] paddr;
    int          hs_cnt;

    fetch_controller #(.WORD_SIZE(32), .PC_INITIAL(32'h0000_0000)) dut (
        .clk(clk), .rst(rst), .PCSrcE(PCSrcE), .PCTargetE(PCTargetE),
        .StallD(StallD), .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ready(imem_ready), .imem_valid(imem_valid), .imem_rdata(imem_rdata),
        .InstrD(InstrD), .PCD(PCD), .PCPlus4D(PCPlus4D), .ValidD(ValidD)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] w(input logic [31:0] a);
        return 32'hC0DE_0000 ^ a;
    endfunction

    // Memory model: accepts on req&ready, answers after lat cycles (lat>=1)
    always @(posedge clk) begin
        imem_valid <= 1'b0;
        if (rst) begin
            pend <= 1'b0;
        end else if (pend) begin
            if (cnt <= 1) begin
                imem_valid <= 1'b1;
                imem_rdata <= w(paddr);
                pend       <= 1'b0;
            end else begin
                cnt <= cnt - 1;
            end
        end else if (imem_req && imem_ready) begin
            hs_cnt <= hs_cnt + 1;
            if (lat <= 1) begin
                imem_valid <= 1'b1;
                imem_rdata <= w(imem_addr);
            end else begin
                pend  <= 1'b1;
                cnt   <= lat - 1;
                paddr <= imem_addr;
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk_dec(input string tag, input logic [31:0] pc);
        chk({tag, "_valid"}, {31'd0, ValidD}, 32'd1);
        chk({tag, "_instr"}, InstrD, w(pc));
        chk({tag, "_pcd"},   PCD, pc);
        chk({tag, "_pc4"},   PCPlus4D, pc + 32'd4);
    endtask

    initial begin
        rst = 1'b1; PCSrcE = 1'b0; PCTargetE = '0; StallD = 1'b0;
        imem_ready = 1'b1; imem_valid = 1'b0; imem_rdata = '0;
        lat = 1; pend = 1'b0; cnt = 0; paddr = '0; hs_cnt = 0;

        // Reset state
        step(); step();
        chk("rst_req",    {31'd0, imem_req}, 32'd0);
        chk("rst_valid",  {31'd0, ValidD}, 32'd0);
        chk("rst_instr",  InstrD, 32'd0);
        chk("rst_pcd",    PCD, 32'd0);
        chk("rst_pc4",    PCPlus4D, 32'd0);
        rst = 1'b0; #1;
        chk("c0_req",  {31'd0, imem_req}, 32'd1);
        chk("c0_addr", imem_addr, 32'h0);

        // Zero-wait streaming: 0, 4, 8
        step();
        chk("c1_req",   {31'd0, imem_req}, 32'd0);
        chk("c1_valid", {31'd0, ValidD}, 32'd0);
        step();
        chk_dec("d0", 32'h0);
        chk("c2_addr", imem_addr, 32'h4);
        chk("c2_req",  {31'd0, imem_req}, 32'd1);
        step();
        chk("c3_valid", {31'd0, ValidD}, 32'd0);
        step();
        chk_dec("d4", 32'h4);
        chk("c4_addr", imem_addr, 32'h8);
        step(); step();
        chk_dec("d8", 32'h8);
        step(); step();
        chk_dec("dC", 32'hC);
        chk("c8_addr", imem_addr, 32'h10);

        // imem_ready low for 3 cycles at 0x10
        imem_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("nrdy_req",  {31'd0, imem_req}, 32'd1);
            chk("nrdy_addr", imem_addr, 32'h10);
        end
        imem_ready = 1'b1;
        step();
        chk("rdy_req", {31'd0, imem_req}, 32'd0);
        chk("hs_cnt",  hs_cnt, 32'd5);
        step();
        chk_dec("d10", 32'h10);
        chk("c13_addr", imem_addr, 32'h14);

        // Decode stall for 4 cycles while response for 0x14 arrives
        StallD = 1'b1;
        step();
        chk_dec("stl0", 32'h10);
        for (int i = 0; i < 3; i++) begin
            step();
            chk_dec("stl", 32'h10);
            chk("hold_req", {31'd0, imem_req}, 32'd0);
        end
        StallD = 1'b0;
        step();
        chk_dec("d14", 32'h14);
        chk("resume_addr", imem_addr, 32'h18);
        chk("resume_req",  {31'd0, imem_req}, 32'd1);

        // Redirect from REQ to 0x40 (memory held off so nothing is issued)
        imem_ready = 1'b0; PCSrcE = 1'b1; PCTargetE = 32'h40;
        step();
        PCSrcE = 1'b0; imem_ready = 1'b1; lat = 3;
        chk("r40_addr",  imem_addr, 32'h40);
        chk("r40_valid", {31'd0, ValidD}, 32'd0);
        step();
        // Now in WAIT for 0x40: redirect to unaligned 0x203
        PCSrcE = 1'b1; PCTargetE = 32'h203;
        step();
        PCSrcE = 1'b0;
        chk("sq_req",   {31'd0, imem_req}, 32'd0);
        chk("sq_valid", {31'd0, ValidD}, 32'd0);
        step();
        chk("sq_valid2", {31'd0, ValidD}, 32'd0);
        step();
        chk("sq_valid3", {31'd0, ValidD}, 32'd0);
        chk("sq_instr",  InstrD, w(32'h14));
        chk("sq_addr",   imem_addr, 32'h200);
        chk("sq_req2",   {31'd0, imem_req}, 32'd1);
        lat = 1;
        step(); step();
        chk_dec("d200", 32'h200);
        chk("c25_addr", imem_addr, 32'h204);

        // Redirect coincident with response and StallD=1
        step();
        chk("coin_ivalid", {31'd0, imem_valid}, 32'd1);
        PCSrcE = 1'b1; PCTargetE = 32'hFFFF_FFFC; StallD = 1'b1;
        step();
        PCSrcE = 1'b0; StallD = 1'b0;
        chk("coin_valid", {31'd0, ValidD}, 32'd0);
        chk("coin_addr",  imem_addr, 32'hFFFF_FFFC);
        chk("coin_req",   {31'd0, imem_req}, 32'd1);
        step(); step();
        chk("wrap_valid", {31'd0, ValidD}, 32'd1);
        chk("wrap_pcd",   PCD, 32'hFFFF_FFFC);
        chk("wrap_pc4",   PCPlus4D, 32'h0);
        chk("wrap_instr", InstrD, w(32'hFFFF_FFFC));
        chk("wrap_addr",  imem_addr, 32'h0);
        step(); step();
        chk_dec("dwrap0", 32'h0);
        chk("c31_addr", imem_addr, 32'h4);

        // Reset while a request is outstanding
        lat = 3;
        step();
        chk("wait_req", {31'd0, imem_req}, 32'd0);
        rst = 1'b1;
        step();
        chk("mrst_valid", {31'd0, ValidD}, 32'd0);
        chk("mrst_pcd",   PCD, 32'h0);
        chk("mrst_instr", InstrD, 32'h0);
        chk("mrst_req",   {31'd0, imem_req}, 32'd0);
        rst = 1'b0; #1;
        chk("mrst_req1",  {31'd0, imem_req}, 32'd1);
        chk("mrst_addr",  imem_addr, 32'h0);
        step(); step(); step(); step();
        chk_dec("dpost", 32'h0);

        // Redirect while holding, with StallD released the same cycle
        lat = 1; StallD = 1'b1;
        step(); step();
        chk("h_req", {31'd0, imem_req}, 32'd0);
        StallD = 1'b0; PCSrcE = 1'b1; PCTargetE = 32'h80;
        step();
        PCSrcE = 1'b0;
        chk("hr_valid", {31'd0, ValidD}, 32'd0);
        chk("hr_instr", InstrD, w(32'h0));
        chk("hr_addr",  imem_addr, 32'h80);
        step();
        chk("hr_valid2", {31'd0, ValidD}, 32'd0);
        step();
        chk_dec("d80", 32'h80);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
